// File: rtl/vrf_read_issue_pipe.sv
// VRF read issue pipe: registers arbitrated read requests, issues them to the
// bank SRAM as {vs, offset}, tracks the fixed SRAM latency with a tag pipe and
// buffers returned data in a response FIFO guarded by a credit counter.
// Optional: define VRF_READ_STALL_CNT_EN to add the io_stall_count output.
module vrf_read_issue_pipe #(
  parameter int VS_W       = 5,
  parameter int OFFSET_W   = 7,
  parameter int SRC_W      = 2,
  parameter int IDX_W      = 3,
  parameter int DATA_W     = 32,
  parameter int READ_LAT   = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     io_in_ready,
  input  logic                     io_in_valid,
  input  logic [VS_W-1:0]          io_in_bits_vs,
  input  logic [SRC_W-1:0]         io_in_bits_readSource,
  input  logic [OFFSET_W-1:0]      io_in_bits_offset,
  input  logic [IDX_W-1:0]         io_in_bits_instructionIndex,
  output logic                     io_sram_ren,
  output logic [VS_W+OFFSET_W-1:0] io_sram_addr,
  input  logic [DATA_W-1:0]        io_sram_rdata,
  input  logic                     io_resp_ready,
  output logic                     io_resp_valid,
  output logic [DATA_W-1:0]        io_resp_bits_data,
  output logic [SRC_W-1:0]         io_resp_bits_readSource,
  output logic [IDX_W-1:0]         io_resp_bits_instructionIndex
`ifdef VRF_READ_STALL_CNT_EN
  ,
  output logic [15:0]              io_stall_count
`endif
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = $clog2(RESP_DEPTH);

  logic             in_fire;
  logic             resp_fire;
  logic             push;
  logic             fifo_full;
  logic [CNT_W-1:0] outstanding;

  logic [SRC_W-1:0] issue_src;
  logic [IDX_W-1:0] issue_idx;

  logic [READ_LAT-1:0]            tag_v;
  logic [READ_LAT-1:0][SRC_W-1:0] tag_src;
  logic [READ_LAT-1:0][IDX_W-1:0] tag_idx;

  logic [DATA_W-1:0] fifo_data [RESP_DEPTH];
  logic [SRC_W-1:0]  fifo_src  [RESP_DEPTH];
  logic [IDX_W-1:0]  fifo_idx  [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  // Ready depends only on the credit register, never on io_resp_ready.
  assign io_in_ready = (outstanding != CNT_W'(RESP_DEPTH));
  assign in_fire     = io_in_valid && io_in_ready;
  assign resp_fire   = io_resp_valid && io_resp_ready;

  // One credit per request from acceptance until its response is popped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else if (in_fire && !resp_fire) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!in_fire && resp_fire) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  // Issue stage: one-cycle ren pulse per accepted request, address held after.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_sram_ren  <= 1'b0;
      io_sram_addr <= '0;
      issue_src    <= '0;
      issue_idx    <= '0;
    end else begin
      io_sram_ren <= in_fire;
      if (in_fire) begin
        io_sram_addr <= {io_in_bits_vs, io_in_bits_offset};
        issue_src    <= io_in_bits_readSource;
        issue_idx    <= io_in_bits_instructionIndex;
      end
    end
  end

  // Tag pipe follows each ren through the SRAM latency; clearing it on reset
  // makes any data still coming out of the SRAM harmless.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_v   <= '0;
      tag_src <= '0;
      tag_idx <= '0;
    end else begin
      tag_v[0]   <= io_sram_ren;
      tag_src[0] <= issue_src;
      tag_idx[0] <= issue_idx;
      for (int k = 1; k < READ_LAT; k++) begin
        tag_v[k]   <= tag_v[k-1];
        tag_src[k] <= tag_src[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  assign push      = tag_v[READ_LAT-1];
  assign fifo_full = (fifo_count == CNT_W'(RESP_DEPTH));

  // Response FIFO storage and pointers; pointers wrap naturally (power of 2).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_src[i]  <= '0;
        fifo_idx[i]  <= '0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= io_sram_rdata;
        fifo_src[wr_ptr]  <= tag_src[READ_LAT-1];
        fifo_idx[wr_ptr]  <= tag_idx[READ_LAT-1];
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (resp_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !resp_fire) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (!push && resp_fire) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  assign io_resp_valid                 = (fifo_count != '0);
  assign io_resp_bits_data             = fifo_data[rd_ptr];
  assign io_resp_bits_readSource       = fifo_src[rd_ptr];
  assign io_resp_bits_instructionIndex = fifo_idx[rd_ptr];

  // Credits make a push into a full FIFO without a same-cycle pop impossible.
  assert property (@(posedge clock) disable iff (reset) !(push && fifo_full && !resp_fire));

`ifdef VRF_READ_STALL_CNT_EN
  // Saturating count of cycles where a request waited for a credit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_stall_count <= '0;
    end else if (io_in_valid && !io_in_ready && (io_stall_count != 16'hFFFF)) begin
      io_stall_count <= io_stall_count + 16'd1;
    end
  end
`else
  // Without the stall counter the datapath above is unchanged.
`endif

endmodule

// File: tb/tb_vrf_read_issue_pipe.sv
// Self-checking bench for vrf_read_issue_pipe: SRAM model, a queue-based
// reference model of the response stream and credits, and scenario tasks.
module tb_vrf_read_issue_pipe;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_in_ready;
  logic        io_in_valid = 1'b0;
  logic [4:0]  io_in_bits_vs = '0;
  logic [1:0]  io_in_bits_readSource = '0;
  logic [6:0]  io_in_bits_offset = '0;
  logic [2:0]  io_in_bits_instructionIndex = '0;
  logic        io_sram_ren;
  logic [11:0] io_sram_addr;
  logic [31:0] io_sram_rdata;
  logic        io_resp_ready = 1'b0;
  logic        io_resp_valid;
  logic [31:0] io_resp_bits_data;
  logic [1:0]  io_resp_bits_readSource;
  logic [2:0]  io_resp_bits_instructionIndex;
`ifdef VRF_READ_STALL_CNT_EN
  logic [15:0] io_stall_count;
`endif

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  src;
    logic [2:0]  idx;
  } resp_t;

  resp_t exp_q[$];
  int    model_out = 0;
  bit    prev_hold = 1'b0;
  resp_t prev_bits;

  vrf_read_issue_pipe dut (
    .clock                         (clock),
    .reset                         (reset),
    .io_in_ready                   (io_in_ready),
    .io_in_valid                   (io_in_valid),
    .io_in_bits_vs                 (io_in_bits_vs),
    .io_in_bits_readSource         (io_in_bits_readSource),
    .io_in_bits_offset             (io_in_bits_offset),
    .io_in_bits_instructionIndex   (io_in_bits_instructionIndex),
    .io_sram_ren                   (io_sram_ren),
    .io_sram_addr                  (io_sram_addr),
    .io_sram_rdata                 (io_sram_rdata),
    .io_resp_ready                 (io_resp_ready),
    .io_resp_valid                 (io_resp_valid),
    .io_resp_bits_data             (io_resp_bits_data),
    .io_resp_bits_readSource       (io_resp_bits_readSource),
    .io_resp_bits_instructionIndex (io_resp_bits_instructionIndex)
`ifdef VRF_READ_STALL_CNT_EN
    ,
    .io_stall_count                (io_stall_count)
`endif
  );

  always #5 clock = ~clock;

  // Contents of the SRAM model: a fixed hash of the address.
  function automatic logic [31:0] mem_fn(input logic [11:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  // SRAM model with a two-cycle read latency; keeps running through reset.
  logic [1:0]  lat_v = '0;
  logic [11:0] lat_a0 = '0;
  logic [11:0] lat_a1 = '0;
  always @(posedge clock) begin
    lat_v  <= {lat_v[0], io_sram_ren};
    lat_a0 <= io_sram_addr;
    lat_a1 <= lat_a0;
  end
  assign io_sram_rdata = lat_v[1] ? mem_fn(lat_a1) : 32'hDEAD_BEEF;

  // Scoreboard: credit model, in-order response queue and hold stability.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      model_out = 0;
      prev_hold = 1'b0;
    end else begin
      checks++;
      if (io_in_ready !== (model_out != DEPTH))
        $display("[TB] FAIL in_ready t=%0t got %b want %b", $time, io_in_ready, model_out != DEPTH);
      else passes++;
      if (prev_hold) begin
        checks++;
        if (io_resp_valid !== 1'b1 ||
            {io_resp_bits_data, io_resp_bits_readSource, io_resp_bits_instructionIndex} !== prev_bits)
          $display("[TB] FAIL resp_hold t=%0t got v=%b %h want v=1 %h", $time, io_resp_valid,
                   {io_resp_bits_data, io_resp_bits_readSource, io_resp_bits_instructionIndex}, prev_bits);
        else passes++;
      end
      if (io_resp_valid) begin
        checks++;
        if (exp_q.size() == 0)
          $display("[TB] FAIL unexpected_resp t=%0t got valid=1 want valid=0", $time);
        else passes++;
      end
      if (io_in_valid && model_out != DEPTH) begin
        exp_q.push_back('{mem_fn({io_in_bits_vs, io_in_bits_offset}),
                          io_in_bits_readSource, io_in_bits_instructionIndex});
        model_out++;
      end
      if (io_resp_valid && io_resp_ready && exp_q.size() > 0) begin
        checks++;
        if ({io_resp_bits_data, io_resp_bits_readSource, io_resp_bits_instructionIndex} !== exp_q[0])
          $display("[TB] FAIL resp_order t=%0t got %h want %h", $time,
                   {io_resp_bits_data, io_resp_bits_readSource, io_resp_bits_instructionIndex}, exp_q[0]);
        else passes++;
        void'(exp_q.pop_front());
        model_out--;
      end
      prev_hold = io_resp_valid && !io_resp_ready;
      prev_bits = {io_resp_bits_data, io_resp_bits_readSource, io_resp_bits_instructionIndex};
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [4:0] vs, input logic [6:0] off,
                         input logic [1:0] src, input logic [2:0] idx);
    io_in_valid                 = v;
    io_in_bits_vs               = vs;
    io_in_bits_offset           = off;
    io_in_bits_readSource       = src;
    io_in_bits_instructionIndex = idx;
  endtask

  task automatic set_rand_req();
    set_req(1'b1, 5'($urandom), 7'($urandom), 2'($urandom), 3'($urandom));
  endtask

  task automatic drain(output bit ok);
    io_in_valid   = 1'b0;
    io_resp_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (model_out == 0 && !io_resp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tick(); tick(); tick();
    checks++;
    if ({io_sram_ren, io_sram_addr, io_resp_valid, io_resp_bits_data,
         io_resp_bits_readSource, io_resp_bits_instructionIndex} !== '0)
      $display("[TB] FAIL reset_outputs got ren=%b addr=%h v=%b d=%h want all 0",
               io_sram_ren, io_sram_addr, io_resp_valid, io_resp_bits_data);
    else passes++;
    reset = 1'b0;
    tick();
    checks++;
    if (io_in_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", io_in_ready);
    else passes++;
  endtask

  task automatic test_single();
    io_resp_ready = 1'b1;
    set_req(1'b1, 5'd3, 7'h05, 2'd1, 3'd2);
    tick();
    io_in_valid = 1'b0;
    checks++;
    if (io_sram_ren !== 1'b1 || io_sram_addr !== 12'h185)
      $display("[TB] FAIL single_issue got ren=%b addr=%h want ren=1 addr=185", io_sram_ren, io_sram_addr);
    else passes++;
    tick();
    checks++;
    if (io_sram_ren !== 1'b0) $display("[TB] FAIL single_ren_pulse got %b want 0", io_sram_ren);
    else passes++;
    tick();
    checks++;
    if (io_resp_valid !== 1'b0) $display("[TB] FAIL single_early got valid=%b want 0", io_resp_valid);
    else passes++;
    tick();
    checks++;
    if (io_resp_valid !== 1'b1 || io_resp_bits_data !== mem_fn(12'h185) ||
        io_resp_bits_readSource !== 2'd1 || io_resp_bits_instructionIndex !== 3'd2)
      $display("[TB] FAIL single_resp got v=%b d=%h s=%0d i=%0d want v=1 d=%h s=1 i=2",
               io_resp_valid, io_resp_bits_data, io_resp_bits_readSource,
               io_resp_bits_instructionIndex, mem_fn(12'h185));
    else passes++;
    tick();
  endtask

  task automatic test_stream();
    int  sent = 0;
    int  rens = 0;
    int  resps = 0;
    bit  prev_fire = 1'b0;
    bit  ok;
    io_resp_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      checks++;
      if (io_sram_ren !== prev_fire)
        $display("[TB] FAIL stream_ren cyc=%0d got %b want %b", cyc, io_sram_ren, prev_fire);
      else passes++;
      if (io_sram_ren) rens++;
      if (io_resp_valid && io_resp_ready) resps++;
      if (sent == 8 && resps == 8 && !io_sram_ren) break;
      if (sent < 8) set_rand_req();
      else io_in_valid = 1'b0;
      prev_fire = io_in_valid && io_in_ready;
      tick();
      if (prev_fire) sent++;
    end
    io_in_valid = 1'b0;
    checks++;
    if (sent != 8 || rens != 8 || resps != 8)
      $display("[TB] FAIL stream_counts got sent=%0d ren=%0d resp=%0d want 8/8/8", sent, rens, resps);
    else passes++;
    drain(ok);
  endtask

  task automatic test_backpressure();
    int k = 0;
    bit ok;
    io_resp_ready = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      set_rand_req();
      if (io_in_ready) begin
        tick();
        k++;
      end else tick();
    end
    checks++;
    if (k != 4 || io_in_ready !== 1'b0)
      $display("[TB] FAIL bp_accepted got %0d ready=%b want 4 ready=0", k, io_in_ready);
    else passes++;
    io_resp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
      set_rand_req();
      if (io_in_ready) begin
        tick();
        k++;
      end else tick();
    end
    io_in_valid = 1'b0;
    checks++;
    if (k != 6) $display("[TB] FAIL bp_resume got %0d want 6", k);
    else passes++;
    drain(ok);
    checks++;
    if (!ok) $display("[TB] FAIL bp_drain got outstanding=%0d want 0", model_out);
    else passes++;
  endtask

  task automatic test_accept_pop();
    bit ok;
    io_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand_req();
      tick();
    end
    io_in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (io_in_ready !== 1'b1 || io_resp_valid !== 1'b1)
      $display("[TB] FAIL ap_setup got ready=%b valid=%b want 1 1", io_in_ready, io_resp_valid);
    else passes++;
    set_rand_req();
    io_resp_ready = 1'b1;
    tick();
    io_in_valid   = 1'b0;
    io_resp_ready = 1'b0;
    checks++;
    if (io_in_ready !== 1'b1) $display("[TB] FAIL ap_same_cycle got ready=%b want 1", io_in_ready);
    else passes++;
    set_rand_req();
    tick();
    io_in_valid = 1'b0;
    checks++;
    if (io_in_ready !== 1'b0) $display("[TB] FAIL ap_full got ready=%b want 0", io_in_ready);
    else passes++;
    drain(ok);
    checks++;
    if (!ok) $display("[TB] FAIL ap_drain got outstanding=%0d want 0", model_out);
    else passes++;
  endtask

  task automatic test_reset_midflight();
    bit seen = 1'b0;
    bit ok;
    io_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand_req();
      tick();
    end
    io_in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({io_sram_ren, io_resp_valid, io_sram_addr, io_resp_bits_data} !== '0 || io_in_ready !== 1'b1)
      $display("[TB] FAIL rst_mid_outputs got ren=%b v=%b addr=%h ready=%b want 0 0 0 1",
               io_sram_ren, io_resp_valid, io_sram_addr, io_in_ready);
    else passes++;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (io_resp_valid !== 1'b0 || io_sram_ren !== 1'b0)
        $display("[TB] FAIL rst_mid_stale cyc=%0d got v=%b ren=%b want 0 0", i, io_resp_valid, io_sram_ren);
      else passes++;
    end
    io_resp_ready = 1'b1;
    set_rand_req();
    tick();
    io_in_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (io_resp_valid) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen) $display("[TB] FAIL rst_mid_roundtrip got no response want one");
    else passes++;
    drain(ok);
  endtask

  task automatic test_random();
    bit ok;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 99) < 60) set_rand_req();
      else io_in_valid = 1'b0;
      io_resp_ready = ($urandom_range(0, 99) < 55);
      tick();
    end
    drain(ok);
    checks++;
    if (!ok) $display("[TB] FAIL random_drain got outstanding=%0d want 0", model_out);
    else passes++;
  endtask

`ifdef VRF_READ_STALL_CNT_EN
  task automatic test_stall_count();
    int exp_stall;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    io_resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_rand_req();
      tick();
    end
    io_in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (io_stall_count !== 16'd0) $display("[TB] FAIL stall_zero got %0d want 0", io_stall_count);
    else passes++;
    io_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    io_in_valid = 1'b0;
    exp_stall = 20;
    checks++;
    if (io_stall_count !== 16'(exp_stall)) $display("[TB] FAIL stall_20 got %0d want %0d", io_stall_count, exp_stall);
    else passes++;
    io_in_valid = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    io_in_valid = 1'b0;
    exp_stall = (exp_stall + 70000 > 65535) ? 65535 : exp_stall + 70000;
    checks++;
    if (io_stall_count !== 16'(exp_stall)) $display("[TB] FAIL stall_sat got %0d want %0d", io_stall_count, exp_stall);
    else passes++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_accept_pop();
    test_reset_midflight();
    test_random();
`ifdef VRF_READ_STALL_CNT_EN
    test_stall_count();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
